// File: rtl/mux8_rr_sched.sv
// ---------------------------------------------------------------------------
// mux8_rr_sched
//   Round-robin scheduler that shares a single 8:1 bit mux among eight
//   requesters. A requester keeps the grant until it drops its request or
//   has held it for MAX_HOLD consecutive cycles. Handover to the next
//   requester happens on the same edge, so there is no idle gap. The
//   selected data bit is registered together with a valid flag.
//
// Ports
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   req    in   8  request per requester (bit k = requester k)
//   din    in   8  data bit per requester (mux inputs)
//   gnt    out  8  registered one-hot grant, zero when idle
//   sel    out  3  registered mux select (index of granted requester)
//   busy   out  1  high while a grant is active
//   y      out  1  registered din[sel], sampled while granted
//   y_vld  out  1  high when y holds a sample taken during a grant
// ---------------------------------------------------------------------------
module mux8_rr_sched #(
   parameter int MAX_HOLD = 4,
   parameter int CNTW     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic [7:0] din,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic       busy,
   output logic       y,
   output logic       y_vld
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [CNTW-1:0] HOLD_LIMIT = CNTW'(MAX_HOLD);

   state_t            state, state_nxt;
   logic [7:0]        gnt_nxt;
   logic [2:0]        sel_nxt;
   logic [2:0]        ptr, ptr_nxt;
   logic [CNTW-1:0]   hcnt, hcnt_nxt;
   logic              y_nxt, y_vld_nxt;
   logic [2:0]        scan_base;
   logic [2:0]        scan_idx;
   logic [2:0]        win_idx;
   logic              win_found;
   logic              release_now;

   // Round-robin search. In IDLE the scan starts at the stored pointer; in
   // GRANT it starts one past the current owner, which is exactly the value
   // the pointer takes on a release, so the current owner is still eligible
   // but is the last candidate examined. Scanning from the far end down lets
   // the closest requester to the base overwrite the others.
   always_comb begin
      scan_base = (state == GRANT) ? sel + 3'd1 : ptr;
      scan_idx  = 3'd0;
      win_idx   = 3'd0;
      win_found = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         scan_idx = scan_base + 3'(i);
         if (req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   // The owner lets go either voluntarily (request dropped) or because its
   // hold budget is used up.
   assign release_now = (state == GRANT) && (!req[sel] || (hcnt == HOLD_LIMIT));

   // Next-state and next-output logic. Everything defaults to holding its
   // value; IDLE only watches for a winner, GRANT samples the mux every cycle
   // and either keeps counting or hands over / goes idle on release.
   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      sel_nxt   = sel;
      ptr_nxt   = ptr;
      hcnt_nxt  = hcnt;
      y_nxt     = y;
      y_vld_nxt = y_vld;
      case (state)
         IDLE: begin
            y_vld_nxt = 1'b0;
            if (win_found) begin
               state_nxt = GRANT;
               gnt_nxt   = 8'b1 << win_idx;
               sel_nxt   = win_idx;
               hcnt_nxt  = CNTW'(1);
            end
         end
         GRANT: begin
            y_nxt     = din[sel];
            y_vld_nxt = 1'b1;
            if (release_now) begin
               ptr_nxt = sel + 3'd1;
               if (win_found) begin
                  gnt_nxt  = 8'b1 << win_idx;
                  sel_nxt  = win_idx;
                  hcnt_nxt = CNTW'(1);
               end else begin
                  state_nxt = IDLE;
                  gnt_nxt   = 8'b0;
                  hcnt_nxt  = '0;
               end
            end else begin
               hcnt_nxt = hcnt + CNTW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = 8'b0;
            hcnt_nxt  = '0;
         end
      endcase
   end

   // State and output registers. Reset clears everything at once, including
   // the round-robin pointer, even in the middle of a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= 8'b0;
         sel   <= 3'd0;
         ptr   <= 3'd0;
         hcnt  <= '0;
         y     <= 1'b0;
         y_vld <= 1'b0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         sel   <= sel_nxt;
         ptr   <= ptr_nxt;
         hcnt  <= hcnt_nxt;
         y     <= y_nxt;
         y_vld <= y_vld_nxt;
      end
   end

   assign busy = (state == GRANT);

endmodule

// File: tb/tb_mux8_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_mux8_rr_sched
//   Directed testbench for mux8_rr_sched. A behavioural model of the
//   round-robin rules tracks the expected outputs every cycle, and a few
//   literal expectations at known points pin the model itself.
// ---------------------------------------------------------------------------
module tb_mux8_rr_sched;

   localparam int MAX_HOLD = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] din;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       busy;
   logic       y;
   logic       y_vld;

   int nCompared   = 0;
   int nMismatched = 0;

   // Model state: who owns the grant, how long it has held it, where the
   // next search starts, and the last sampled data bit.
   bit mBusy;
   int mOwner;
   int mHeld;
   int mPtr;
   bit mY;
   bit mYv;

   mux8_rr_sched #(.MAX_HOLD(MAX_HOLD), .CNTW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .din   (din),
      .gnt   (gnt),
      .sel   (sel),
      .busy  (busy),
      .y     (y),
      .y_vld (y_vld)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison helper shared by the model checker and the literal
   // checks, so every check steps the same counters.
   task automatic compareVal(input string name, input int actual, input int expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Search for the first active request starting at position p, wrapping.
   function automatic int findWinner(input logic [7:0] r, input int p);
      for (int i = 0; i < 8; i++) begin
         if (r[(p + i) % 8]) return (p + i) % 8;
      end
      return -1;
   endfunction

   task automatic modelReset();
      mBusy  = 1'b0;
      mOwner = 0;
      mHeld  = 0;
      mPtr   = 0;
      mY     = 1'b0;
      mYv    = 1'b0;
   endtask

   // One clock edge of the scheduling rules, written in terms of owner and
   // elapsed hold time rather than hardware registers.
   task automatic modelStep();
      int w;
      if (!mBusy) begin
         mYv = 1'b0;
         w = findWinner(req, mPtr);
         if (w >= 0) begin
            mBusy  = 1'b1;
            mOwner = w;
            mHeld  = 1;
         end
      end else begin
         mY  = din[mOwner];
         mYv = 1'b1;
         if (!req[mOwner] || mHeld == MAX_HOLD) begin
            mPtr = (mOwner + 1) % 8;
            w = findWinner(req, mPtr);
            if (w >= 0) begin
               mOwner = w;
               mHeld  = 1;
            end else begin
               mBusy = 1'b0;
               mHeld = 0;
            end
         end else begin
            mHeld++;
         end
      end
   endtask

   task automatic checkOutput();
      compareVal("model gnt", int'(gnt), mBusy ? (1 << mOwner) : 0);
      compareVal("model busy", int'(busy), int'(mBusy));
      compareVal("model y_vld", int'(y_vld), int'(mYv));
      compareVal("model y", int'(y), int'(mY));
      if (mBusy) compareVal("model sel", int'(sel), mOwner);
   endtask

   // Model advances on every active edge and is compared 1 ns later; it
   // follows the asynchronous reset directly.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         modelReset();
      end else begin
         modelStep();
         #1 checkOutput();
      end
   end

   // Inputs change on the falling edge, well away from the sampling edge.
   task automatic applyStimulus(input logic [7:0] r, input logic [7:0] d);
      @(negedge clk);
      req = r;
      din = d;
   endtask

   // Advance past the next active edge and the model comparison.
   task automatic nextEdge();
      @(posedge clk);
      #2;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 8'h00;
      din   = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 8'h00;
      din   = 8'h00;
      modelReset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Idle with no requests.
      $display("[TB] test 1: idle after reset");
      applyStimulus(8'h00, 8'h00);
      for (int i = 0; i < 5; i++) begin
         nextEdge();
         compareVal("t1 gnt", int'(gnt), 0);
         compareVal("t1 busy", int'(busy), 0);
         compareVal("t1 y_vld", int'(y_vld), 0);
      end

      // Single requester, data path latency, release to idle.
      $display("[TB] test 2: single request");
      applyStimulus(8'h04, 8'h04);
      nextEdge();
      compareVal("t2 gnt", int'(gnt), 4);
      compareVal("t2 sel", int'(sel), 2);
      compareVal("t2 y_vld early", int'(y_vld), 0);
      nextEdge();
      compareVal("t2 y", int'(y), 1);
      compareVal("t2 y_vld", int'(y_vld), 1);
      applyStimulus(8'h00, 8'h04);
      nextEdge();
      compareVal("t2 gnt release", int'(gnt), 0);
      compareVal("t2 busy release", int'(busy), 0);
      nextEdge();
      compareVal("t2 y_vld drop", int'(y_vld), 0);
      compareVal("t2 y held", int'(y), 1);

      // All requesting: each index held MAX_HOLD cycles, busy never drops.
      $display("[TB] test 3: full rotation");
      doReset();
      applyStimulus(8'hFF, 8'hA5);
      for (int c = 0; c < 9 * MAX_HOLD; c++) begin
         nextEdge();
         compareVal("t3 sel", int'(sel), (c / MAX_HOLD) % 8);
         compareVal("t3 busy", int'(busy), 1);
      end
      applyStimulus(8'h00, 8'h00);
      repeat (2) nextEdge();

      // Voluntary release hands over directly to the next requester.
      $display("[TB] test 4: early release");
      doReset();
      applyStimulus(8'h0A, 8'h02);
      nextEdge();
      compareVal("t4 sel first", int'(sel), 1);
      nextEdge();
      compareVal("t4 sel second", int'(sel), 1);
      applyStimulus(8'h08, 8'h02);
      nextEdge();
      compareVal("t4 sel handover", int'(sel), 3);
      compareVal("t4 gnt handover", int'(gnt), 8);
      applyStimulus(8'h00, 8'h00);
      repeat (2) nextEdge();

      // Pointer wrap after serving requester 6.
      $display("[TB] test 5: pointer wrap");
      doReset();
      applyStimulus(8'h40, 8'h00);
      nextEdge();
      compareVal("t5 sel6", int'(sel), 6);
      applyStimulus(8'h00, 8'h00);
      repeat (2) nextEdge();
      applyStimulus(8'h82, 8'h80);
      nextEdge();
      compareVal("t5 sel7", int'(sel), 7);
      applyStimulus(8'h02, 8'h80);
      nextEdge();
      compareVal("t5 sel1", int'(sel), 1);
      compareVal("t5 y", int'(y), 1);
      applyStimulus(8'h00, 8'h00);
      repeat (2) nextEdge();

      // Asynchronous reset in the middle of a grant.
      $display("[TB] test 6: reset mid-grant");
      doReset();
      applyStimulus(8'h20, 8'h20);
      nextEdge();
      compareVal("t6 sel5", int'(sel), 5);
      nextEdge();
      compareVal("t6 y before reset", int'(y), 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      compareVal("t6 gnt reset", int'(gnt), 0);
      compareVal("t6 sel reset", int'(sel), 0);
      compareVal("t6 busy reset", int'(busy), 0);
      compareVal("t6 y reset", int'(y), 0);
      compareVal("t6 y_vld reset", int'(y_vld), 0);
      @(negedge clk);
      req   = 8'hFF;
      din   = 8'h00;
      rst_n = 1'b1;
      nextEdge();
      compareVal("t6 sel after reset", int'(sel), 0);
      compareVal("t6 gnt after reset", int'(gnt), 1);
      applyStimulus(8'h00, 8'h00);
      repeat (6) nextEdge();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
